spi_master: RTL

//   SPI initiator (mode 0, MSB first): the driving end of the 40-bit read frame that spi_slave answers.
//   A Start pulse sends an 8-bit address, then clocks 32 data bits back and returns them on DataFromSlave.

---
 rtl/spi_master_if.sv | 33 +++
 rtl/spi_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_if
// Description : Bundle of the SPI initiator's request/response signals and
//               its four-wire SPI pins. The master modport is the initiator's
//               view; the slave modport is the requester/peripheral side.
// Revision    : 1.0  initial release
// ============================================================================
interface spi_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              Start;
    logic [ADDR_W-1:0] Addr;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] DataFromSlave;
    logic              SPI_CLK;
    logic              SPI_CS;
    logic              SPI_MOSI;
    logic              SPI_MISO;

    modport master (
        input  Start, Addr, SPI_MISO,
        output Busy, Done, DataFromSlave, SPI_CLK, SPI_CS, SPI_MOSI
    );

    modport slave (
        output Start, Addr, SPI_MISO,
        input  Busy, Done, DataFromSlave, SPI_CLK, SPI_CS, SPI_MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0, MSB-first SPI initiator. A Start request sends an
//               address and then clocks a data word back from the slave.
//               SCLK is generated by dividing Clk; every pin is registered.
// Revision    : 1.0  initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV = 25,   // Clk cycles per SCLK half-period, 4..255
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  wire logic    Clk,
    input  wire logic    Reset_n,
    spi_master_if.master bus
);

    // Divider and bit counters are sized so a legal frame never wraps them.
    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
    localparam logic [5:0] c_last_bit = 6'(ADDR_W + DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [7:0]        r_div;
    logic [5:0]        r_bit;
    logic [ADDR_W-1:0] r_addr_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_data;
    logic              r_sclk;
    logic              r_cs;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;

    logic              w_div_end;

    // End of the current half-period / SETUP / HOLD interval.
    assign w_div_end = (r_div == c_div_last);

    // Frame sequencer: owns every output so all pins come straight from flops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_div     <= 8'd0;
            r_bit     <= 6'd0;
            r_addr_sr <= '0;
            r_rx_sr   <= '0;
            r_data    <= '0;
            r_sclk    <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_addr_sr <= bus.Addr;
                        r_mosi    <= bus.Addr[ADDR_W-1];
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div     <= 8'd0;
                        r_state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_div_end) begin
                        // First rising edge; MISO is captured on the same Clk edge.
                        r_div   <= 8'd0;
                        r_bit   <= 6'd0;
                        r_sclk  <= 1'b1;
                        r_rx_sr <= {r_rx_sr[DATA_W-2:0], bus.SPI_MISO};
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= 8'd0;
                        if (r_sclk) begin
                            // Falling edge: present the next address bit; zeros
                            // shift in behind the address for the data phase.
                            r_sclk    <= 1'b0;
                            r_mosi    <= r_addr_sr[ADDR_W-2];
                            r_addr_sr <= {r_addr_sr[ADDR_W-2:0], 1'b0};
                        end else if (r_bit == c_last_bit) begin
                            // Low half of the final bit has elapsed.
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk  <= 1'b1;
                            r_bit   <= r_bit + 6'd1;
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], bus.SPI_MISO};
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_HOLD: begin
                    if (w_div_end) begin
                        // Address bits have long since shifted out of the
                        // DATA_W-wide receive register, leaving only data.
                        r_div   <= 8'd0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_data  <= r_rx_sr;
                        r_state <= S_DONE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.SPI_CLK       = r_sclk;
    assign bus.SPI_CS        = r_cs;
    assign bus.SPI_MOSI      = r_mosi;
    assign bus.Busy          = r_busy;
    assign bus.Done          = r_done;
    assign bus.DataFromSlave = r_data;

endmodule
`default_nettype wire
